// File: rtl/k86_bus_pkg.sv
// -----------------------------------------------------------------------------
// k86_bus_pkg
//   Shared encodings and default sizes for the k86 memory bus.
//   Contents:
//     phase_e    - slot phase: PH_ADDR (address/write presented),
//                  PH_DATA (read data returning from RAM)
//     owner_e    - slot owner: OWN_CPU (x86 core), OWN_VID (video fetcher)
//     *_DEF      - default widths and burst limit for mem_arbiter
//     arb_owner  - owner selection for the next slot
// -----------------------------------------------------------------------------
package k86_bus_pkg;

   localparam int ADDR_W_DEF        = 20;
   localparam int DATA_W_DEF        = 8;
   localparam int VID_BURST_MAX_DEF = 4;
   localparam int CNT_W_DEF         = 3;

   typedef enum logic {
      PH_ADDR = 1'b0,
      PH_DATA = 1'b1
   } phase_e;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_VID = 1'b1
   } owner_e;

   // Video has fixed priority unless the starvation guard forces a CPU slot.
   // With no video request the slot goes to the CPU, so slots are never empty.
   function automatic owner_e arb_owner(input logic vid_req, input logic force_cpu);
      return (vid_req && !force_cpu) ? OWN_VID : OWN_CPU;
   endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// -----------------------------------------------------------------------------
// arb_starve_cnt
//   Counts consecutive video slots granted by mem_arbiter and raises force_o
//   once BURST_MAX of them have been granted in a row, so the next slot goes
//   to the CPU. Only instantiated when ARB_FAIR_EN is defined.
//   Ports:
//     clk_i        in   system clock
//     rst_n_i      in   asynchronous active-low reset
//     arb_i        in   high in the cycle whose closing edge arbitrates a slot
//     vid_grant_i  in   the slot being arbitrated goes to video
//     force_o      out  counter is at BURST_MAX; next slot must be CPU
// -----------------------------------------------------------------------------
module arb_starve_cnt
   import k86_bus_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEF,
   parameter int BURST_MAX = VID_BURST_MAX_DEF
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic arb_i,
   input  logic vid_grant_i,
   output logic force_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign force_o = (cnt_q == CNT_W'(BURST_MAX));

   always_comb begin
      cnt_d = cnt_q;
      if (arb_i) begin
         // A forced CPU slot or any ordinary CPU slot ends the video run.
         if (force_o || !vid_grant_i) begin
            cnt_d = '0;
         end else if (cnt_q != CNT_W'(BURST_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one synchronous RAM between the x86 core and the video fetcher.
//   Time is cut into 2-clock slots (PH_ADDR then PH_DATA). The owner of each
//   slot is decided on the edge that ends the previous slot's PH_DATA; video
//   has priority. The core is advanced by a one-cycle cpu_ce pulse per CPU
//   slot, the video fetcher gets a one-cycle vid_ack pulse per video slot.
//   Both pulses land in the PH_ADDR cycle after their slot, while the RAM
//   output still holds the word read for that slot.
//
//   Build option:
//     ARB_FAIR_EN  defined   -> after VID_BURST_MAX consecutive video slots the
//                               next slot is forced to the CPU
//                  undefined -> pure video priority; the CPU can starve
//
//   Ports:
//     clock, reset_n             system clock, async active-low reset
//     cpu_address/cpu_out/cpu_we core request (held stable between cpu_ce)
//     cpu_in, cpu_ce             read data and clock enable to the core
//     vid_req, vid_addr          video read request, held until vid_ack
//     vid_ack, vid_data          video completion pulse and read data
//     mem_address/mem_out/mem_we RAM address, write data, write enable
//     mem_in                     RAM read data, one clock after address
//
//   state        | meaning
//   -------------+---------------------------------------------------------
//   PH_ADDR      | address (and CPU write) presented to RAM for owner_q
//   PH_DATA      | RAM returns read data; closing edge arbitrates next slot
// -----------------------------------------------------------------------------
module mem_arbiter
   import k86_bus_pkg::*;
#(
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int DATA_W        = DATA_W_DEF,
   parameter int VID_BURST_MAX = VID_BURST_MAX_DEF,
   parameter int CNT_W         = CNT_W_DEF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic [DATA_W-1:0] cpu_out,
   input  logic              cpu_we,
   output logic [DATA_W-1:0] cpu_in,
   output logic              cpu_ce,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic [DATA_W-1:0] vid_data,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_out,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_in
);

   phase_e phase_q;
   phase_e phase_d;
   owner_e owner_q;
   owner_e owner_d;
   logic   cpu_ce_q;
   logic   cpu_ce_d;
   logic   vid_ack_q;
   logic   vid_ack_d;
   logic   arb_edge;
   logic   force_cpu;

`ifdef ARB_FAIR_EN
   arb_starve_cnt #(
      .CNT_W     (CNT_W),
      .BURST_MAX (VID_BURST_MAX)
   ) u_starve (
      .clk_i       (clock),
      .rst_n_i     (reset_n),
      .arb_i       (arb_edge),
      .vid_grant_i (vid_req && !force_cpu),
      .force_o     (force_cpu)
   );
`else
   assign force_cpu = 1'b0;

   // Burst parameters and the arbitration strobe only matter to the fairness
   // counter; sink them so the plain-priority build stays warning-free.
   logic unused_fair_cfg;
   assign unused_fair_cfg = arb_edge ^ (|CNT_W'(VID_BURST_MAX));
`endif

   always_comb begin
      phase_d   = (phase_q == PH_ADDR) ? PH_DATA : PH_ADDR;
      owner_d   = owner_q;
      cpu_ce_d  = 1'b0;
      vid_ack_d = 1'b0;
      arb_edge  = 1'b0;
      if (phase_q == PH_DATA) begin
         // Slot completes on this edge: pulse its owner, pick the next owner.
         arb_edge  = 1'b1;
         cpu_ce_d  = (owner_q == OWN_CPU);
         vid_ack_d = (owner_q == OWN_VID);
         owner_d   = arb_owner(vid_req, force_cpu);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         phase_q   <= PH_ADDR;
         owner_q   <= OWN_CPU;
         cpu_ce_q  <= 1'b0;
         vid_ack_q <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         owner_q   <= owner_d;
         cpu_ce_q  <= cpu_ce_d;
         vid_ack_q <= vid_ack_d;
      end
   end

   // Address is held from the same source across both phases of the slot.
   assign mem_address = (owner_q == OWN_VID) ? vid_addr : cpu_address;
   assign mem_out     = cpu_out;

   // reset_n is folded in so a write in flight is dropped the instant reset
   // asserts, not at the next clock.
   assign mem_we = reset_n && (owner_q == OWN_CPU) && (phase_q == PH_ADDR) && cpu_we;

   assign cpu_ce   = cpu_ce_q;
   assign vid_ack  = vid_ack_q;
   assign cpu_in   = mem_in;
   assign vid_data = mem_in;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   logic        clock;
   logic        reset_n;
   logic [19:0] cpu_address;
   logic [7:0]  cpu_out;
   logic        cpu_we;
   logic [7:0]  cpu_in;
   logic        cpu_ce;
   logic        vid_req;
   logic [19:0] vid_addr;
   logic        vid_ack;
   logic [7:0]  vid_data;
   logic [19:0] mem_address;
   logic [7:0]  mem_out;
   logic        mem_we;
   logic [7:0]  mem_in;

   int passed = 0;
   int total  = 0;

   mem_arbiter dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .cpu_address (cpu_address),
      .cpu_out     (cpu_out),
      .cpu_we      (cpu_we),
      .cpu_in      (cpu_in),
      .cpu_ce      (cpu_ce),
      .vid_req     (vid_req),
      .vid_addr    (vid_addr),
      .vid_ack     (vid_ack),
      .vid_data    (vid_data),
      .mem_address (mem_address),
      .mem_out     (mem_out),
      .mem_we      (mem_we),
      .mem_in      (mem_in)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous RAM model: read data registered one clock after address.
   logic [7:0] ram [0:(1<<20)-1];
   logic [7:0] rd_q;
   always @(posedge clock) begin
      if (mem_we) ram[mem_address] <= mem_out;
      rd_q <= ram[mem_address];
   end
   assign mem_in = rd_q;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int         ce_cnt;
      int         ce_even;
      int         we_bad;
      int         we_pulses;
      int         lat;
      logic [7:0] vdat;
      logic [23:0] ce_v, ack_v, exp_ce, exp_ack;

      reset_n     = 1'b0;
      cpu_address = 20'h12345;
      cpu_out     = 8'h00;
      cpu_we      = 1'b1;
      vid_req     = 1'b0;
      vid_addr    = 20'h0ABCD;

      // Reset state
      repeat (3) tick();
      check("rst_cpu_ce",  32'(cpu_ce), 32'h0);
      check("rst_vid_ack", 32'(vid_ack), 32'h0);
      check("rst_mem_we",  32'(mem_we), 32'h0);
      check("rst_mem_addr", 32'(mem_address), 32'h12345);

      // Test 1: CPU only for 20 clocks
      cpu_address = 20'h00010;
      @(negedge clock) reset_n = 1'b1;
      ce_cnt = 0; ce_even = 0; we_bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (cpu_ce) begin
            ce_cnt++;
            if (i % 2 == 0) ce_even++;
         end
         if (mem_we !== cpu_ce) we_bad++;
      end
      check("t1_ce_count", 32'(ce_cnt), 32'd10);
      check("t1_ce_phase", 32'(ce_even), 32'd0);
      check("t1_we_only_addr", 32'(we_bad), 32'd0);

      // Test 2: CPU write 400 <= 5A, then read it back (now in PH_ADDR of a CPU slot)
      cpu_address = 20'h00400; cpu_out = 8'h5A; cpu_we = 1'b1;
      we_pulses = 0;
      #1 if (mem_we) we_pulses++;
      tick(); if (mem_we) we_pulses++;
      tick(); cpu_we = 1'b0;
      #1 if (mem_we) we_pulses++;
      check("t2_we_pulses", 32'(we_pulses), 32'd1);
      tick(); tick();
      check("t2_rd_ce", 32'(cpu_ce), 32'h1);
      check("t2_rd_data", 32'(cpu_in), 32'h5A);
      // load the video word through the CPU port
      cpu_address = 20'h0B800; cpu_out = 8'h41; cpu_we = 1'b1;
      tick(); tick();
      cpu_we = 1'b0; cpu_address = 20'h00000;

      // Test 3: video read while a CPU slot is in its PH_ADDR
      vid_req = 1'b1; vid_addr = 20'h0B800;
      lat = 0; vdat = 8'h00;
      for (int t = 1; t <= 8; t++) begin
         tick();
         if (vid_ack && lat == 0) begin
            lat  = t;
            vdat = vid_data;
            break;
         end
      end
      check("t3_latency", 32'(lat), 32'd4);
      check("t3_vid_data", 32'(vdat), 32'h41);
      vid_req = 1'b0;
      tick(); tick();
      check("t3_granted_slot_acks", 32'(vid_ack), 32'h1);

      // Test 6: vid_req raised in PH_DATA with CPU write pending
      tick();
      vid_req = 1'b1; vid_addr = 20'h0B801;
      cpu_address = 20'h00500; cpu_out = 8'hEE; cpu_we = 1'b1;
      tick();
      check("t6_inflight_ce", 32'(cpu_ce), 32'h1);
      check("t6_vid_addr", 32'(mem_address), 32'h0B801);
      check("t6_no_cpu_we", 32'(mem_we), 32'h0);
      vid_req = 1'b0;
      tick(); tick();
      check("t6_vid_ack", 32'(vid_ack), 32'h1);
      check("t6_no_ce", 32'(cpu_ce), 32'h0);
      cpu_we = 1'b0;

      // Test 5: reset during PH_ADDR of a CPU write
      cpu_address = 20'h00400; cpu_out = 8'hA5; cpu_we = 1'b1;
      #1 check("t5_we_before", 32'(mem_we), 32'h1);
      #1 reset_n = 1'b0;
      #1 check("t5_we_async_drop", 32'(mem_we), 32'h0);
      tick(); check("t5_ce_in_rst_a", 32'(cpu_ce), 32'h0);
      tick(); check("t5_ce_in_rst_b", 32'(cpu_ce), 32'h0);
      cpu_we = 1'b0;
      @(negedge clock) reset_n = 1'b1;
      tick(); tick();
      check("t5_first_slot_ce", 32'(cpu_ce), 32'h1);
      check("t5_ram_untouched", 32'(cpu_in), 32'h5A);

      // Test 4: vid_req held from reset exit for 24 clocks
      reset_n = 1'b0;
      vid_req = 1'b1; vid_addr = 20'h0B800;
      tick();
      @(negedge clock) reset_n = 1'b1;
      ce_v = '0; ack_v = '0; exp_ce = '0; exp_ack = '0;
      for (int i = 0; i < 24; i++) begin
         tick();
         ce_v[i]  = cpu_ce;
         ack_v[i] = vid_ack;
      end
      // Slot k reports in cycle 2k+1; slot 0 is the CPU slot owned at reset.
      for (int k = 0; k < 12; k++) begin
`ifdef ARB_FAIR_EN
         if (k % 5 == 0) exp_ce[2*k+1] = 1'b1;
         else            exp_ack[2*k+1] = 1'b1;
`else
         if (k == 0) exp_ce[2*k+1] = 1'b1;
         else        exp_ack[2*k+1] = 1'b1;
`endif
      end
      check("t4_ce_pattern", 32'(ce_v), 32'(exp_ce));
      check("t4_ack_pattern", 32'(ack_v), 32'(exp_ack));
      check("t4_never_both", 32'(ce_v & ack_v), 32'h0);
      vid_req = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
